// File: rtl/inv_sub_bytes_iter.sv
// Purpose: AES inverse SubBytes over a 128-bit state, BPC bytes per cycle through BPC inverse S-boxes.
// Latency: out_valid rises NSTEP = 16/BPC cycles after the input handshake.
// Backpressure: result is held in DONE until out_ready; no input is accepted while BUSY or DONE.
module inv_sub_bytes_iter #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] sr_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] sb_out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int NSTEP = 16 / BPC;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  // FIPS-197 inverse S-box; entry b sits at bits [(255-b)*8 +: 8] (entry 0 is the MSB byte).
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic [6:0]      lane_base [BPC];
  logic [7:0]      sub_byte  [BPC];

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = 11'((255 - int'(b)) * 8);
    return INV_SBOX[pos +: 8];
  endfunction

  // One combinational inverse S-box per lane; lane j handles byte cnt*BPC+j, MSB-first.
  for (genvar j = 0; j < BPC; j++) begin : g_lane
    assign lane_base[j] = 7'((15 - (int'(cnt_q) * BPC + j)) * 8);
    assign sub_byte[j]  = inv_sbox(work_q[lane_base[j] +: 8]);
  end

  // State, step counter and working register; reset clears any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Next-state: capture in IDLE, substitute one group per cycle in BUSY, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        // sr_in is only looked at when in_valid is high, so X on an idle bus stays out.
        if (in_valid) begin
          work_d  = sr_in;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < BPC; j++) begin
          work_d[lane_base[j] +: 8] = sub_byte[j];
        end
        if (cnt_q == CW'(NSTEP - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sb_out    = work_q;

endmodule
